// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter; a grant is held until its owner drops req.
// Optional hold limit: define RR_ARB_TIMEOUT_EN to revoke any grant after MAX_HOLD cycles.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] req_rot;
    logic [2:0] rot_idx;
    logic [2:0] win;
    logic       owner_req;
    logic       limit_hit;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter8: MAX_HOLD must be within 2..255");
    end

    // LSB-first 8-to-3 encode; the loop runs high to low so the lowest set bit wins.
    function automatic logic [2:0] lsb_index(input logic [7:0] v);
        lsb_index = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lsb_index = 3'(i);
        end
    endfunction

    // Rotate ptr down to bit 0 so plain lowest-bit priority gives round-robin order.
    assign req_rot   = (req >> ptr) | (req << (4'd8 - {1'b0, ptr}));
    assign rot_idx   = lsb_index(req_rot);
    assign win       = ptr + rot_idx;
    assign owner_req = req[gnt_idx];

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    // A release on the same edge wins over the limit, so no timeout pulse then.
    assign limit_hit = owner_req && (hold_cnt == 8'(MAX_HOLD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            timeout <= (state == GRANT) && limit_hit;
            if (state == IDLE && req != 8'h00) begin
                hold_cnt <= 8'd1;
            end else if (state == GRANT && owner_req && !limit_hit) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end
`else
    assign limit_hit = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            case (state)
                IDLE: begin
                    if (req != 8'h00) begin
                        gnt       <= 8'h01 << win;
                        gnt_idx   <= win;
                        gnt_valid <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req || limit_hit) begin
                        gnt       <= 8'h00;
                        gnt_idx   <= 3'd0;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + 3'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: behavioural model feeds a scoreboard queue per clock.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic m_valid;
    int   m_idx;
    int   m_ptr;
    int   m_cnt;
    logic m_to;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] r);
        m_to = 1'b0;
        if (!m_valid) begin
            for (int k = 0; k < 8; k++) begin
                int j;
                j = (m_ptr + k) % 8;
                if (r[j]) begin
                    m_idx   = j;
                    m_valid = 1'b1;
                    m_cnt   = 1;
                    break;
                end
            end
        end else if (!r[m_idx]) begin
            m_ptr   = (m_idx + 1) % 8;
            m_valid = 1'b0;
            m_idx   = 0;
        end
`ifdef RR_ARB_TIMEOUT_EN
        else if (m_cnt == MAX_HOLD) begin
            m_ptr   = (m_idx + 1) % 8;
            m_valid = 1'b0;
            m_idx   = 0;
            m_to    = 1'b1;
        end else begin
            m_cnt++;
        end
`endif
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("gnt", 32'(gnt), 32'(e.gnt));
            check("gnt_idx", 32'(gnt_idx), 32'(e.idx));
            check("gnt_valid", 32'(gnt_valid), 32'(e.valid));
            check("timeout", 32'(timeout), 32'(e.to));
        end
    endtask

    // Drive one cycle of req, predict the post-edge outputs, then compare after the edge.
    task automatic step(input logic [7:0] r);
        exp_t e;
        req = r;
        model_edge(r);
        e.gnt   = m_valid ? (8'h01 << m_idx) : 8'h00;
        e.idx   = 3'(m_idx);
        e.valid = m_valid;
        e.to    = m_to;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'h00);
        check({tag, "_idx"}, 32'(gnt_idx), 32'd0);
        check({tag, "_valid"}, 32'(gnt_valid), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    logic [7:0] rot_tab [8] = '{8'h81, 8'h80, 8'h81, 8'h01, 8'h81, 8'h80, 8'h81, 8'h01};

    initial begin
        rst = 1'b1;
        req = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;

        step(8'h00);
        step(8'h00);

        // Single requester 5, then ptr=6 shows through the next grant
        step(8'h20);
        check("single_idx", 32'(gnt_idx), 32'd5);
        step(8'h20);
        step(8'h00);
        step(8'hFF);
        check("ptr6_idx", 32'(gnt_idx), 32'd6);
        step(8'h00);

        // Wrap-around: ptr=7, so requester 0 beats 6
        step(8'h41);
        check("wrap_idx", 32'(gnt_idx), 32'd0);
        step(8'h40);
        step(8'h40);
        step(8'h00);

        // Asynchronous reset mid-grant with all requests up
        step(8'hFF);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_cleared("rst_held");
        step(8'hFF);
        check("post_rst_idx", 32'(gnt_idx), 32'd0);
        step(8'h00);
        step(8'h00);

        // Rotation between 0 and 7 with one idle cycle between grants
        model_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        foreach (rot_tab[i]) step(rot_tab[i]);

        // Owner 2 ignores random activity on req[7:3]
        step(8'h04);
        for (int i = 0; i < 10; i++) step({5'($urandom), 3'b100});
        check("ignore_hold", 32'(gnt), 32'h04);
        step({5'($urandom), 3'b000});
        step(8'h00);

`ifdef RR_ARB_TIMEOUT_EN
        // Hold limit: 4 grant cycles, timeout pulse, idle, re-grant of 3
        for (int i = 0; i < 8; i++) step(8'h08);
        step(8'h00);
        step(8'h00);
        // Release on the limit edge: release wins, no pulse
        for (int i = 0; i < 4; i++) step(8'h08);
        step(8'h00);
        check("limit_release_to", 32'(timeout), 32'd0);
`else
        for (int i = 0; i < 20; i++) step(8'h08);
        check("no_limit_gnt", 32'(gnt), 32'h08);
        step(8'h00);
`endif

        // Random traffic against the model
        for (int i = 0; i < 80; i++) step(8'($urandom) & 8'($urandom));
        step(8'h00);
        step(8'h00);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one resource among eight requesters. It encodes the request vector into a 3-bit winner index, in the same way as the team's 8-to-3 encoder, but rotates priority after every grant. The grant is held until the owner releases it. It sits between eight request sources and a single shared datapath, driving a one-hot grant and a binary index for the datapath mux select.

## Interface
- MAX_HOLD, 16: maximum grant length in cycles when the timeout feature is compiled in; legal range 2..255.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  8  request vector; bit i is requester i and is level-sensitive
- gnt  output  8  one-hot grant, or all zeros
- gnt_idx  output  3  binary index of the current owner; 0 when gnt_valid=0
- gnt_valid  output  1  high while any grant is active
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit; constant 0 without the macro

## Operation
- The design has one clock; reset is asynchronous and active-high.
- All outputs are registered.
- Reset values:
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0
  - state=IDLE, priority pointer ptr=3'd0, hold counter=0
- States:
  - IDLE: no owner.
  - GRANT: one owner, identified by gnt_idx.
- IDLE behaviour:
  - If req==0, stay in IDLE and leave the outputs unchanged.
  - Otherwise, search req starting at bit ptr, upward with wrap (ptr, ptr+1, …, 7, 0, …, ptr-1). The first set bit wins.
  - At the next edge: gnt=1<<win, gnt_idx=win, gnt_valid=1, state=GRANT, hold counter=1.
- GRANT behaviour:
  - While req[gnt_idx]=1, hold the grant. Changes on other req bits are ignored.
  - When req[gnt_idx]=0 is sampled at an edge, that edge does the following: gnt=0, gnt_valid=0, gnt_idx=0, ptr=(old gnt_idx+1) mod 8, state=IDLE.
- The arbiter always spends one IDLE cycle between successive grants; there is no direct handoff.
- Pointer arithmetic is 3-bit with natural wrap, so 7+1=0.
- A requester that drops req while in IDLE, before it is granted, is simply not considered.
- When rst is asserted during GRANT, the grant clears immediately (asynchronously) and ptr returns to 0.

## Timing
- Latency from req rising (sampled at edge N, block in IDLE, requester wins) to gnt high: visible after edge N. That is one cycle.
- Latency from owner req falling (sampled at edge M) to gnt low: visible after edge M.
- Earliest next grant: after edge M+1.
- Minimum grant width is 1 cycle, which happens when req drops on the cycle after the grant.
- Steady-state throughput with continuous single-cycle requests: one grant every 2 cycles.
- timeout is high for exactly the one cycle following the revoking edge.

## Configuration
- RR_ARB_TIMEOUT_EN defined:
  - The hold counter increments each cycle in GRANT.
  - When the counter equals MAX_HOLD at an edge, that edge revokes the grant exactly like a release: gnt=0, ptr=owner+1, state=IDLE. It also sets timeout=1 for one cycle.
  - The result is that gnt stays high for at most MAX_HOLD cycles.
  - If the release and the limit occur on the same edge, the release takes precedence and timeout stays 0.
- RR_ARB_TIMEOUT_EN undefined:
  - There is no counter.
  - A grant lasts until release.
  - timeout is tied to 0.

## Test plan
- Reset: assert rst mid-simulation with req=8'hFF → on the same edge gnt=8'h00, gnt_idx=0, gnt_valid=0, timeout=0; after release, the first grant goes to requester 0.
- Single requester: req=8'h20 from IDLE → gnt=8'h20, gnt_idx=5 one cycle later; drop req → gnt=0 next cycle, and ptr=6 is observable via the next grant order.
- Rotation: from reset, hold req=8'h81 and release each owner one cycle after its grant → grant sequence 0, 7, 0, 7 with one idle cycle between each pair.
- Wrap-around: grant and release requester 6 (ptr=7), then req=8'h41 → requester 0 is granted before 6.
- Ignore others while owned: grant 2, then toggle req[7:3] randomly for 10 cycles → gnt stays 8'h04 until req[2]=0.
- Timeout (RR_ARB_TIMEOUT_EN, MAX_HOLD=4): hold req=8'h08 → gnt=8'h08 for exactly 4 cycles, a timeout pulse follows, one idle cycle passes, then requester 3 is re-granted.
